bcd_down_timer: RTL and testbench

- Multi-digit BCD countdown timer: the down-counting, borrow-chained counterpart of the team's decimal up-counter with carry-out.
- Loads a BCD preset, decrements one unit per tick_en while running, and flags expiry with a registered borrow and a one-cycle done pulse.
- Sits in the lab datapath behind a prescaler (tick_en) and drives seven-segment display logic and control FSMs.

---
 rtl/bcd_down_timer.sv | 142 ++++++++++++++
 tb/tb_bcd_down_timer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with borrow-chained digits, pause/resume and expiry flags.
// Optional AUTO_RELOAD_EN: on expiry, reload the last accepted preset and keep running.
module bcd_down_timer #(
  parameter int DIGITS   = 2,
  parameter int PRESET_W = 4*DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PRESET_W-1:0] preset,
  input  logic                start,
  input  logic                pause,
  input  logic                tick_en,
  output logic [PRESET_W-1:0] count,
  output logic                bo,
  output logic                running,
  output logic                done,
  output logic                preset_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_reg;
  logic [PRESET_W-1:0] count_reg;
  logic [PRESET_W-1:0] reload_reg;
  logic                bo_reg;
  logic                done_reg;
  logic                preset_err_reg;

  logic [DIGITS-1:0]   digit_ok;
  logic [DIGITS-1:0]   borrow;
  logic [PRESET_W-1:0] count_dec;
  logic                preset_valid;
  logic                count_zero;
  logic                count_is_one;

  // Per-digit validity check and ripple-borrow decrement; each digit stays within 0-9.
  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit        = count_reg[4*gi +: 4];
      assign digit_ok[gi] = (preset[4*gi +: 4] <= 4'd9);
      assign count_dec[4*gi +: 4] = !borrow[gi]     ? digit :
                                    (digit == 4'd0) ? 4'd9  : digit - 4'd1;
      if (gi < DIGITS-1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (digit == 4'd0);
      end
    end
  endgenerate

  assign preset_valid = &digit_ok;
  assign count_zero   = (count_reg == '0);
  assign count_is_one = (count_reg == PRESET_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      reload_reg     <= '0;
      bo_reg         <= 1'b0;
      done_reg       <= 1'b0;
      preset_err_reg <= 1'b0;
    end else begin
      done_reg       <= 1'b0;
      preset_err_reg <= 1'b0;
      if (load) begin
        // A rejected load consumes the cycle: nothing else acts.
        if (preset_valid) begin
          count_reg  <= preset;
          reload_reg <= preset;
          bo_reg     <= 1'b0;
          state_reg  <= IDLE;
        end else begin
          preset_err_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (!pause && start && !count_zero)
              state_reg <= RUN;
          end
          RUN: begin
`ifdef AUTO_RELOAD_EN
            bo_reg <= 1'b0;
`endif
            if (pause) begin
              state_reg <= PAUSED;
            end else if (tick_en) begin
              if (count_is_one) begin
                done_reg <= 1'b1;
                bo_reg   <= 1'b1;
`ifdef AUTO_RELOAD_EN
                if (reload_reg != '0) begin
                  count_reg <= reload_reg;
                end else begin
                  count_reg <= '0;
                  state_reg <= DONE;
                end
`else
                count_reg <= '0;
                state_reg <= DONE;
`endif
              end else begin
                count_reg <= count_dec;
              end
            end
          end
          PAUSED: begin
            if (!pause && start)
              state_reg <= RUN;
          end
          DONE: begin
            count_reg <= '0;
            bo_reg    <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifndef AUTO_RELOAD_EN
  // Reload value is captured but has no consumer in this build.
  logic unused_reload;
  assign unused_reload = ^reload_reg;
`endif

  assign count      = count_reg;
  assign bo         = bo_reg;
  assign running    = (state_reg == RUN);
  assign done       = done_reg;
  assign preset_err = preset_err_reg;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer (DIGITS=2); define AUTO_RELOAD_EN to test periodic mode.
module tb_bcd_down_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] preset;
  logic       start;
  logic       pause;
  logic       tick_en;
  logic [7:0] count;
  logic       bo;
  logic       running;
  logic       done;
  logic       preset_err;

  int total = 0;
  int bad   = 0;

  bcd_down_timer #(.DIGITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .preset     (preset),
    .start      (start),
    .pause      (pause),
    .tick_en    (tick_en),
    .count      (count),
    .bo         (bo),
    .running    (running),
    .done       (done),
    .preset_err (preset_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Apply one cycle of inputs, then return 1 ns after the edge with inputs idle.
  task automatic step(input logic r, input logic l, input logic [7:0] p,
                      input logic s, input logic pa, input logic t);
    rst = r; load = l; preset = p; start = s; pause = pa; tick_en = t;
    @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick_en = 1'b0;
  endtask

  logic [7:0] exp_seq [12];
`ifdef AUTO_RELOAD_EN
  logic [7:0] auto_seq [6];
  int         done_cnt;
`endif

  initial begin
    exp_seq = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    rst = 1'b1; load = 1'b0; preset = 8'h00; start = 1'b0; pause = 1'b0; tick_en = 1'b0;

    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    check("rst_count", count, 8'h00);
    check("rst_bo", bo, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_perr", preset_err, 0);

`ifndef AUTO_RELOAD_EN
    // Full countdown from 12
    step(0, 1, 8'h12, 0, 0, 0);
    check("load12_count", count, 8'h12);
    check("load12_idle", running, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    check("start_running", running, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 8'h00, 0, 0, 1);
      check($sformatf("tick%0d_count", i), count, exp_seq[i]);
      check($sformatf("tick%0d_done", i), done, (i == 11) ? 1 : 0);
      check($sformatf("tick%0d_bo", i), bo, (i == 11) ? 1 : 0);
    end
    check("expired_running", running, 0);
    step(0, 0, 8'h00, 1, 0, 1);
    check("done_pulse_cleared", done, 0);
    check("done_bo_held", bo, 1);
    check("done_count_held", count, 8'h00);
    check("done_ignores_start", running, 0);

    // Borrow across the digit boundary; zero start ignored
    step(0, 1, 8'h20, 0, 0, 0);
    check("load20_bo_clear", bo, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    check("borrow_20_to_19", count, 8'h19);
    step(0, 1, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    check("zero_start_idle", running, 0);
    check("zero_start_nodone", done, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    check("zero_start_nodone2", done, 0);
    check("zero_count", count, 8'h00);

    // Pause / resume
    step(0, 1, 8'h05, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 1);
    check("pre_pause_count", count, 8'h03);
    step(0, 0, 8'h00, 0, 1, 1);
    check("pause_with_tick_count", count, 8'h03);
    check("paused_not_running", running, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 0, 1);
    check("paused_hold_count", count, 8'h03);
    step(0, 0, 8'h00, 1, 1, 0);
    check("start_pause_stays_paused", running, 0);
    step(0, 0, 8'h00, 1, 0, 1);
    check("resume_running", running, 1);
    check("resume_no_dec", count, 8'h03);
    step(0, 0, 8'h00, 0, 0, 1);
    check("resume_tick", count, 8'h02);

    // Rejected and accepted loads
    step(0, 1, 8'h1A, 0, 0, 0);
    check("bad_load_err", preset_err, 1);
    check("bad_load_count", count, 8'h02);
    check("bad_load_state", running, 1);
    step(0, 0, 8'h00, 0, 0, 0);
    check("bad_load_err_pulse", preset_err, 0);
    step(0, 1, 8'h99, 0, 0, 0);
    check("load99_count", count, 8'h99);
    check("load99_err", preset_err, 0);
    check("load99_idle", running, 0);

    // Load beats tick mid-run; reset mid-run
    step(0, 1, 8'h07, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 1, 8'h30, 0, 0, 1);
    check("load_over_tick_count", count, 8'h30);
    check("load_over_tick_idle", running, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    check("tick_30_to_29", count, 8'h29);
    step(1, 0, 8'h00, 0, 0, 1);
    check("midrun_rst_count", count, 8'h00);
    check("midrun_rst_running", running, 0);
    check("midrun_rst_bo", bo, 0);
    check("midrun_rst_done", done, 0);
`else
    // Periodic mode
    auto_seq = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
    done_cnt = 0;
    step(0, 1, 8'h03, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 8'h00, 0, 0, 1);
      if (done) done_cnt++;
      check($sformatf("auto%0d_count", i), count, auto_seq[i]);
      check($sformatf("auto%0d_bo", i), bo, (i == 2 || i == 5) ? 1 : 0);
      check($sformatf("auto%0d_running", i), running, 1);
    end
    check("auto_done_count", done_cnt, 2);
    step(0, 0, 8'h00, 0, 0, 0);
    check("auto_bo_pulse", bo, 0);
    check("auto_done_pulse", done, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
